instr_mem_sync: RTL and testbench
=================================

// Module: instr_mem_sync
// PURPOSE
//  Parametrised synchronous instruction memory for the MIPS/RISC-V style core.
//  Sits between the PC/fetch stage and the decoder.
//  Replaces the fixed 64x32 combinational ROM with a loadable RAM:
//   - a LOAD phase streams a program in word by word;
//   - a RUN phase serves registered fetches with 1-cycle latency, stall hold and
//     fault signalling.
// PARAMETERS
//  DATA_W  32           instruction word width (bits)
//  DEPTH   64           number of instruction words
//  ADDR_W  8            byte-address width; must satisfy 2^(ADDR_W-2) >= DEPTH
//  NOP     32'h00000013 word returned on a fault (addi x0,x0,0)
// PORTS
//  clk          in   1         rising-edge clock
//  reset        in   1         synchronous, active-high reset
//  ld_valid     in   1         load word strobe (LOAD state only)
//  ld_data      in   DATA_W    word written at ld_ptr
//  ld_done      in   1         end-of-program pulse; LOAD->RUN
//  ld_count     out  $clog2(DEPTH+1)  words loaded since reset
//  running      out  1         1 when state==RUN
//  req          in   1         fetch request (RUN state only)
//  addr         in   ADDR_W    byte address of the fetch
//  hold         in   1         stall: freeze fetch outputs
//  rvalid       out  1         instruction valid, 1 cycle after accepted req
//  instruction  out  DATA_W    fetched word (registered)
//  fault        out  1         accepted req was misaligned or out of range
// BEHAVIOUR
//  Reset:
//   - state=LOAD, ld_ptr=0, ld_count=0, running=0;
//   - rvalid=0, fault=0, instruction=NOP;
//   - memory array NOT cleared, so a program survives reset.
//  FSM LOAD:
//   - ld_valid writes mem[ld_ptr]<=ld_data, then ld_ptr and ld_count increment.
//   - ld_done -> RUN next cycle.
//   - ld_valid with ld_ptr==DEPTH-1 writes that last word, then -> RUN (full).
//   - ld_valid and ld_done in the same cycle: the word is written, then -> RUN.
//   - ld_done with ld_count==0 -> RUN; the memory holds its prior contents.
//   - req is ignored in LOAD: rvalid stays 0.
//  FSM RUN:
//   - Stays in RUN until reset; ld_valid and ld_done are ignored.
//   - Reset mid-load or mid-fetch returns to LOAD with ld_ptr=0 and the outputs
//     at their reset values.
//  Fetch:
//   - A req is accepted when state==RUN and hold==0.
//   - Index is addr[ADDR_W-1:2].
//   - The next edge registers rvalid=1 and one of:
//       - valid access: instruction=mem[index], fault=0;
//       - addr[1:0]!=0 or index>=DEPTH: instruction=NOP, fault=1.
//   - No accepted req: rvalid=0. instruction and fault keep their last values.
//   - Back-to-back accepted reqs give one result per cycle (throughput 1).
//   - hold==1: rvalid, instruction and fault are frozen; req that cycle is
//     dropped, and the fetch stage re-presents it.
//   - Read-during-write cannot occur, because loading and fetching are in
//     mutually exclusive states.
//  Widths: index compare is unsigned. ld_count saturates at DEPTH.
// STRUCTURE
//  Shared package: state encoding (ST_LOAD, ST_RUN) and the NOP constant.
//  The core package reuses both.
//  Single natural sub-module: imem_ram (DEPTH x DATA_W, 1 write port, 1
//  registered read port), so it can map to block RAM. FSM and fault logic live
//  in the top module.
// TESTING
//  1 Load 18 words (0x00007033, 0x00100093, ...), pulse ld_done, req addr=0x08
//    -> next cycle rvalid=1, instruction=0x00200113, fault=0; ld_count=18.
//  2 In RUN, req addr=0x06 -> rvalid=1, instruction=0x00000013, fault=1;
//    req addr=0xFC with DEPTH=63 -> fault=1.
//  3 Back-to-back reqs 0x00,0x04,0x08; hold=1 during the second result
//    -> second word held 2 cycles; third req issued under hold is dropped.
//  4 Stream DEPTH words with no ld_done -> running=1 the cycle after the 64th
//    write; a further ld_valid does not change mem[0].
//  5 req in LOAD -> rvalid stays 0. Assert reset mid-load after 5 words
//    -> ld_count=0, state LOAD, mem[0..4] retained.
//  6 ld_valid and ld_done in the same cycle with ld_data=0xDEADBEEF at ptr 3
//    -> running=1; fetch addr=0x0C returns 0xDEADBEEF.

Source files
------------

// File: rtl/instr_mem_sync_pkg.sv
// instr_mem_sync_pkg: shared state encoding and fault-fill instruction word
package instr_mem_sync_pkg;
  typedef enum logic {ST_LOAD, ST_RUN} state_t;
  localparam logic [31:0] NOP_WORD = 32'h00000013;
endpackage

// File: rtl/imem_ram.sv
// imem_ram: single write port, registered read port with read enable (block-RAM friendly)
module imem_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/instr_mem_sync.sv
// instr_mem_sync: loadable instruction RAM with LOAD/RUN phases and 1-cycle registered fetch
module instr_mem_sync
  import instr_mem_sync_pkg::*;
#(
  parameter int                DATA_W = 32,
  parameter int                DEPTH  = 64,
  parameter int                ADDR_W = 8,
  parameter logic [DATA_W-1:0] NOP    = DATA_W'(NOP_WORD)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ld_valid,
  input  logic [DATA_W-1:0]          ld_data,
  input  logic                       ld_done,
  output logic [$clog2(DEPTH+1)-1:0] ld_count,
  output logic                       running,
  input  logic                       req,
  input  logic [ADDR_W-1:0]          addr,
  input  logic                       hold,
  output logic                       rvalid,
  output logic [DATA_W-1:0]          instruction,
  output logic                       fault
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = ADDR_W - 2;
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
  localparam logic [IW:0]   DEPTH_X = (IW+1)'(DEPTH);
  state_t            state;
  logic [AW-1:0]     ld_ptr;
  logic [IW-1:0]     idx;
  logic              acc, ok, use_ram;
  logic [DATA_W-1:0] ram_q;
  assign idx     = addr[ADDR_W-1:2];
  assign acc     = (state == ST_RUN) && req && !hold;
  assign ok      = (addr[1:0] == 2'b00) && ({1'b0, idx} < DEPTH_X);
  assign running = (state == ST_RUN);
  // RAM read register only advances on a valid accepted fetch, so it doubles as the held output
  assign instruction = use_ram ? ram_q : NOP;
  imem_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    ((state == ST_LOAD) && ld_valid),
    .waddr (ld_ptr),
    .wdata (ld_data),
    .re    (acc && ok),
    .raddr (idx[AW-1:0]),
    .rdata (ram_q)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_LOAD;
      ld_ptr   <= '0;
      ld_count <= '0;
      rvalid   <= 1'b0;
      fault    <= 1'b0;
      use_ram  <= 1'b0;
    end else begin
      if (state == ST_LOAD) begin
        if (ld_valid) begin
          ld_ptr <= ld_ptr + 1'b1;
          if (ld_count != CNT_MAX) ld_count <= ld_count + 1'b1;
        end
        if (ld_done || (ld_valid && ld_ptr == LAST)) state <= ST_RUN;
      end
      if (!hold) begin
        rvalid <= acc;
        if (acc) begin
          fault   <= !ok;
          use_ram <= ok;
        end
      end
    end
  end
endmodule

// File: tb/tb_instr_mem_sync.sv
// tb_instr_mem_sync: directed table-driven checks plus multi-cycle load/fetch/hold sequences
module tb_instr_mem_sync;
  import instr_mem_sync_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        reset, ld_valid, ld_done, req, hold, running, rvalid, fault;
  logic [31:0] ld_data, instruction;
  logic [6:0]  ld_count;
  logic [7:0]  addr;
  logic        ld_valid2, ld_done2, req2, hold2, running2, rvalid2, fault2;
  logic [31:0] ld_data2, instruction2;
  logic [6:0]  ld_count2;
  logic [7:0]  addr2;
  int checks = 0, errors = 0;
  typedef struct {logic [7:0] a; logic [31:0] ins; logic f;} vec_t;
  vec_t vt[8];

  instr_mem_sync dut (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_data(ld_data), .ld_done(ld_done),
    .ld_count(ld_count), .running(running), .req(req), .addr(addr), .hold(hold),
    .rvalid(rvalid), .instruction(instruction), .fault(fault)
  );
  instr_mem_sync #(.DEPTH(63)) dut63 (
    .clk(clk), .reset(reset), .ld_valid(ld_valid2), .ld_data(ld_data2), .ld_done(ld_done2),
    .ld_count(ld_count2), .running(running2), .req(req2), .addr(addr2), .hold(hold2),
    .rvalid(rvalid2), .instruction(instruction2), .fault(fault2)
  );

  function automatic logic [31:0] prog(int i);
    return (i == 0) ? 32'h00007033 : ((32'(i) << 20) | (32'(i) << 7) | 32'h13);
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1; ld_valid = 0; ld_done = 0; req = 0; hold = 0;
    step();
    reset = 0;
  endtask

  task automatic load(logic [31:0] w);
    ld_valid = 1; ld_data = w;
    step();
    ld_valid = 0;
  endtask

  task automatic fetch(logic [7:0] a);
    req = 1; addr = a;
    step();
    req = 0;
  endtask

  initial begin
    reset = 0; ld_valid = 0; ld_data = '0; ld_done = 0; req = 0; addr = '0; hold = 0;
    ld_valid2 = 0; ld_data2 = '0; ld_done2 = 0; req2 = 0; addr2 = '0; hold2 = 0;
    do_reset();
    chk("rst_running", 32'(running), 0);
    chk("rst_ld_count", 32'(ld_count), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_instr", instruction, NOP_WORD);
    fetch(8'h00);
    chk("load_req_rvalid", 32'(rvalid), 0);
    for (int i = 0; i < 5; i++) load(32'h50000000 + 32'(i));
    chk("midload_count", 32'(ld_count), 5);
    do_reset();
    chk("midload_rst_count", 32'(ld_count), 0);
    chk("midload_rst_running", 32'(running), 0);
    ld_done = 1;
    step();
    ld_done = 0;
    chk("empty_done_running", 32'(running), 1);
    chk("empty_done_count", 32'(ld_count), 0);
    for (int i = 0; i < 5; i++) begin
      fetch(8'(i * 4));
      chk($sformatf("retained_%0d", i), instruction, 32'h50000000 + 32'(i));
    end
    do_reset();
    for (int i = 0; i < 18; i++) load(prog(i));
    chk("load18_running_pre", 32'(running), 0);
    ld_done = 1;
    step();
    ld_done = 0;
    chk("load18_running", 32'(running), 1);
    chk("load18_count", 32'(ld_count), 18);
    vt[0] = '{8'h08, 32'h00200113, 1'b0};
    vt[1] = '{8'h00, 32'h00007033, 1'b0};
    vt[2] = '{8'h44, prog(17), 1'b0};
    vt[3] = '{8'h04, 32'h00100093, 1'b0};
    vt[4] = '{8'h01, NOP_WORD, 1'b1};
    vt[5] = '{8'h0C, prog(3), 1'b0};
    vt[6] = '{8'h3E, NOP_WORD, 1'b1};
    vt[7] = '{8'h06, NOP_WORD, 1'b1};
    for (int i = 0; i < 8; i++) begin
      fetch(vt[i].a);
      chk($sformatf("vec%0d_rvalid", i), 32'(rvalid), 1);
      chk($sformatf("vec%0d_instr", i), instruction, vt[i].ins);
      chk($sformatf("vec%0d_fault", i), 32'(fault), 32'(vt[i].f));
    end
    step();
    chk("idle_rvalid", 32'(rvalid), 0);
    chk("idle_fault_kept", 32'(fault), 1);
    req = 1; addr = 8'h00;
    step();
    chk("b2b0_instr", instruction, prog(0));
    addr = 8'h04;
    step();
    chk("b2b1_instr", instruction, prog(1));
    chk("b2b1_rvalid", 32'(rvalid), 1);
    hold = 1; addr = 8'h08;
    step();
    chk("hold_rvalid", 32'(rvalid), 1);
    chk("hold_instr", instruction, prog(1));
    hold = 0; req = 0;
    step();
    chk("drop_rvalid", 32'(rvalid), 0);
    chk("drop_instr_kept", instruction, prog(1));
    fetch(8'h02);
    chk("prerst_fault", 32'(fault), 1);
    do_reset();
    chk("midfetch_rst_rvalid", 32'(rvalid), 0);
    chk("midfetch_rst_fault", 32'(fault), 0);
    chk("midfetch_rst_instr", instruction, NOP_WORD);
    chk("midfetch_rst_running", 32'(running), 0);
    for (int i = 0; i < 3; i++) load(prog(i));
    ld_valid = 1; ld_done = 1; ld_data = 32'hDEADBEEF;
    step();
    ld_valid = 0; ld_done = 0;
    chk("same_cycle_running", 32'(running), 1);
    chk("same_cycle_count", 32'(ld_count), 4);
    fetch(8'h0C);
    chk("same_cycle_word", instruction, 32'hDEADBEEF);
    chk("same_cycle_fault", 32'(fault), 0);
    do_reset();
    for (int i = 0; i < 64; i++) begin
      load(32'hA0000000 + 32'(i));
      if (i == 62) chk("full_running_63", 32'(running), 0);
    end
    chk("full_running", 32'(running), 1);
    chk("full_count", 32'(ld_count), 64);
    load(32'hFFFFFFFF);
    chk("full_count_sat", 32'(ld_count), 64);
    fetch(8'h00);
    chk("full_mem0", instruction, 32'hA0000000);
    fetch(8'hFC);
    chk("full_mem63", instruction, 32'hA000003F);
    chk("full_mem63_fault", 32'(fault), 0);
    ld_done2 = 1;
    step();
    ld_done2 = 0;
    chk("d63_running", 32'(running2), 1);
    req2 = 1; addr2 = 8'hFC;
    step();
    chk("d63_oor_rvalid", 32'(rvalid2), 1);
    chk("d63_oor_fault", 32'(fault2), 1);
    chk("d63_oor_instr", instruction2, NOP_WORD);
    addr2 = 8'hF8;
    step();
    req2 = 0;
    chk("d63_last_fault", 32'(fault2), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
